// File: rtl/ratio_job_issuer.sv
// Initiator for the (a*b)/(c*d) engine: FIFO-queued jobs, start/done launch, valid/ready result.
// Optional saturating result counters (stat_jobs/stat_errs) when RATIO_ISSUER_STATS_EN is defined.
module ratio_job_issuer #(
  parameter int DEPTH   = 4,
  parameter int OPW     = 16,
  parameter int RESW    = 32,
  parameter int TIMEOUT = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       job_valid,
  output logic                       job_ready,
  input  logic [OPW-1:0]             job_a,
  input  logic [OPW-1:0]             job_b,
  input  logic [OPW-1:0]             job_c,
  input  logic [OPW-1:0]             job_d,
  output logic                       eng_start,
  output logic [OPW-1:0]             eng_a,
  output logic [OPW-1:0]             eng_b,
  output logic [OPW-1:0]             eng_c,
  output logic [OPW-1:0]             eng_d,
  input  logic                       eng_done,
  input  logic [RESW-1:0]            eng_out,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [RESW-1:0]            res_data,
  output logic                       res_err,
  output logic                       busy,
  output logic [$clog2(DEPTH+1)-1:0] jobs_pending
`ifdef RATIO_ISSUER_STATS_EN
  ,
  output logic [15:0]                stat_jobs,
  output logic [15:0]                stat_errs
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    RESULT = 2'd3
  } state_t;

  state_t state;
  state_t next_state;

  logic [4*OPW-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic [OPW-1:0]   head_a;
  logic [OPW-1:0]   head_b;
  logic [OPW-1:0]   head_c;
  logic [OPW-1:0]   head_d;
  logic             zero_div;
  logic             done_q;
  logic             done_edge;
  logic [TW-1:0]    timer;
  logic             timed_out;

  assign full         = (count == CW'(DEPTH));
  assign empty        = (count == {CW{1'b0}});
  assign job_ready    = !full;
  assign jobs_pending = count;
  assign push         = job_valid && !full;
  assign busy         = (state != IDLE);

  assign {head_a, head_b, head_c, head_d} = mem[rd_ptr];
  assign zero_div  = (head_c == {OPW{1'b0}}) || (head_d == {OPW{1'b0}});
  // An edge needs a low sample first, so a done level held from before launch never completes a job.
  assign done_edge = eng_done && !done_q;
  assign timed_out = (timer == TW'(TIMEOUT - 1));

  // FIFO storage write
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {job_a, job_b, job_c, job_d};
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= {AW{1'b0}};
      rd_ptr <= {AW{1'b0}};
      count  <= {CW{1'b0}};
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // FSM next state and FIFO pop
  always_comb begin
    next_state = state;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop = 1'b1;
          if (zero_div) next_state = RESULT;
          else          next_state = LAUNCH;
        end else begin
          next_state = IDLE;
        end
      end
      LAUNCH: next_state = WAIT;
      WAIT: begin
        if (done_edge || timed_out) next_state = RESULT;
        else                        next_state = WAIT;
      end
      RESULT: begin
        if (res_ready) next_state = IDLE;
        else           next_state = RESULT;
      end
      default: next_state = IDLE;
    endcase
  end

  // Engine operands, launch pulse, wait timer and result register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      eng_start <= 1'b0;
      eng_a     <= {OPW{1'b0}};
      eng_b     <= {OPW{1'b0}};
      eng_c     <= {OPW{1'b0}};
      eng_d     <= {OPW{1'b0}};
      res_valid <= 1'b0;
      res_data  <= {RESW{1'b0}};
      res_err   <= 1'b0;
      done_q    <= 1'b0;
      timer     <= {TW{1'b0}};
    end else begin
      done_q    <= eng_done;
      eng_start <= pop && !zero_div;
      case (state)
        IDLE: begin
          if (pop) begin
            if (zero_div) begin
              res_data  <= {RESW{1'b1}};
              res_err   <= 1'b1;
              res_valid <= 1'b1;
            end else begin
              eng_a <= head_a;
              eng_b <= head_b;
              eng_c <= head_c;
              eng_d <= head_d;
            end
          end
        end
        LAUNCH: timer <= {TW{1'b0}};
        WAIT: begin
          timer <= timer + TW'(1);
          // A completion arriving in the timeout cycle still delivers the engine result.
          if (done_edge) begin
            res_data  <= eng_out;
            res_err   <= 1'b0;
            res_valid <= 1'b1;
          end else if (timed_out) begin
            res_data  <= {RESW{1'b0}};
            res_err   <= 1'b1;
            res_valid <= 1'b1;
          end
        end
        RESULT: begin
          if (res_ready) res_valid <= 1'b0;
        end
        default: res_valid <= 1'b0;
      endcase
    end
  end

`ifdef RATIO_ISSUER_STATS_EN
  logic handshake;
  assign handshake = (state == RESULT) && res_ready;

  // Saturating counters of delivered results and of error results
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_jobs <= 16'h0000;
      stat_errs <= 16'h0000;
    end else begin
      if (handshake && (stat_jobs != 16'hFFFF)) stat_jobs <= stat_jobs + 16'd1;
      if (handshake && res_err && (stat_errs != 16'hFFFF)) stat_errs <= stat_errs + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ratio_job_issuer.sv
// Randomized self-checking bench for ratio_job_issuer with a behavioural engine and result scoreboard.
module tb_ratio_job_issuer;
  localparam int DEPTH   = 4;
  localparam int OPW     = 16;
  localparam int RESW    = 32;
  localparam int TIMEOUT = 64;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            job_valid;
  logic            job_ready;
  logic [OPW-1:0]  job_a, job_b, job_c, job_d;
  logic            eng_start;
  logic [OPW-1:0]  eng_a, eng_b, eng_c, eng_d;
  logic            eng_done;
  logic [RESW-1:0] eng_out;
  logic            res_valid;
  logic            res_ready;
  logic [RESW-1:0] res_data;
  logic            res_err;
  logic            busy;
  logic [2:0]      jobs_pending;
`ifdef RATIO_ISSUER_STATS_EN
  logic [15:0]     stat_jobs, stat_errs;
`endif

  ratio_job_issuer #(.DEPTH(DEPTH), .OPW(OPW), .RESW(RESW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .job_valid(job_valid), .job_ready(job_ready),
    .job_a(job_a), .job_b(job_b), .job_c(job_c), .job_d(job_d),
    .eng_start(eng_start), .eng_a(eng_a), .eng_b(eng_b), .eng_c(eng_c), .eng_d(eng_d),
    .eng_done(eng_done), .eng_out(eng_out),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_err(res_err),
    .busy(busy), .jobs_pending(jobs_pending)
`ifdef RATIO_ISSUER_STATS_EN
    , .stat_jobs(stat_jobs), .stat_errs(stat_errs)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [32:0] exp_q[$];     // expected {err, data} in delivery order
  logic [63:0] launch_q[$];  // expected engine operands in launch order
  int eng_mode  = 0;         // 0 done after delay, 1 silent, 2 done stuck high, 3 stuck high then re-rise
  int eng_delay = 0;         // 0 selects a random delay
  int push_cyc  = 0;
  int start_cyc = 0;
  int start_count = 0;
  logic rr_random = 1'b0;
  logic rr_level  = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  // Expected outcome of a job: expect_timeout says the engine will not produce a valid completion.
  function automatic logic [32:0] ref_result(input logic [15:0] a, b, c, d, input bit expect_timeout);
    longint unsigned num, den;
    logic [63:0] q;
    if (c == 16'd0 || d == 16'd0) return {1'b1, 32'hFFFF_FFFF};
    if (expect_timeout) return {1'b1, 32'h0};
    num = a; num = num * b;
    den = c; den = den * d;
    q = num / den;
    return {1'b0, q[31:0]};
  endfunction

  task automatic push_job(input logic [15:0] a, b, c, d, input bit expect_timeout);
    int t;
    bit ok;
    t = 0; ok = 1'b0;
    @(posedge clk); #1;
    job_valid = 1'b1; job_a = a; job_b = b; job_c = c; job_d = d;
    while (!ok && t <= 2000) begin
      @(negedge clk);
      if (job_ready) ok = 1'b1;
      else t++;
    end
    if (!ok) check("push_timeout", 64'(t), 64'd0);
    else begin
      push_cyc = cyc;
      exp_q.push_back(ref_result(a, b, c, d, expect_timeout));
      if (c != 16'd0 && d != 16'd0) launch_q.push_back({a, b, c, d});
    end
    @(posedge clk); #1;
    job_valid = 1'b0;
  endtask

  task automatic wait_res(input int budget, output int rise);
    int t;
    t = 0;
    do begin @(negedge clk); t++; end while (!res_valid && t < budget);
    if (!res_valid) check("res_valid_timeout", 64'(t), 64'd0);
    rise = cyc;
  endtask

  task automatic wait_drain(input int budget);
    int t;
    t = 0;
    do begin @(negedge clk); t++; end
    while ((busy || jobs_pending != 3'd0 || exp_q.size() != 0) && t < budget);
    check("drain_busy", 64'({busy, jobs_pending}), 64'd0);
    check("drain_results_left", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_job_ready"}, 64'(job_ready), 64'd1);
    check({tag, "_busy_pending"}, 64'({busy, jobs_pending}), 64'd0);
    check({tag, "_res"}, 64'({res_valid, res_err, res_data}), 64'd0);
    check({tag, "_eng"}, {eng_a, eng_b, eng_c, eng_d}, 64'd0);
    check({tag, "_start"}, 64'(eng_start), 64'd0);
  endtask

  // Behavioural engine
  initial begin
    logic [32:0] r;
    int dly;
    eng_done = 1'b0; eng_out = 32'd0;
    forever begin
      @(negedge clk);
      eng_done = (eng_mode == 2 || eng_mode == 3);
      if (rst_n && eng_start) begin
        r = ref_result(eng_a, eng_b, eng_c, eng_d, 1'b0);
        if (eng_mode == 0) begin
          if (eng_delay > 0) dly = eng_delay;
          else if ($urandom_range(0, 9) == 0) dly = TIMEOUT;
          else dly = $urandom_range(1, 14);
          repeat (dly) @(posedge clk);
          #1; eng_out = r[31:0]; eng_done = 1'b1;
          @(posedge clk); #1; eng_done = 1'b0;
        end else if (eng_mode == 3) begin
          repeat (3) @(posedge clk);
          #1; eng_done = 1'b0;
          repeat (2) @(posedge clk);
          #1; eng_out = r[31:0]; eng_done = 1'b1;
          @(posedge clk); #1; eng_done = 1'b0;
        end
      end
    end
  end

  // Downstream ready driver
  initial begin
    res_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      res_ready = rr_random ? 1'($urandom_range(0, 1)) : rr_level;
    end
  end

  // Launch and result monitor
  initial begin
    logic prev_start, prev_valid, in_flight;
    logic [63:0] cur_op;
    logic [32:0] e;
    prev_start = 1'b0; prev_valid = 1'b0; in_flight = 1'b0; cur_op = 64'd0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete(); launch_q.delete();
        in_flight = 1'b0; prev_start = 1'b0; prev_valid = 1'b0;
      end else begin
        if (res_valid && !prev_valid) in_flight = 1'b0;
        if (eng_start) begin
          start_count++;
          start_cyc = cyc;
          check("start_one_cycle", 64'(prev_start), 64'd0);
          if (launch_q.size() == 0) check("start_unexpected", 64'(launch_q.size()), 64'd1);
          else begin
            cur_op = launch_q.pop_front();
            check("launch_ops", {eng_a, eng_b, eng_c, eng_d}, cur_op);
            in_flight = 1'b1;
          end
        end else if (in_flight) begin
          check("ops_held", {eng_a, eng_b, eng_c, eng_d}, cur_op);
        end
        if (res_valid && res_ready) begin
          if (exp_q.size() == 0) check("result_unexpected", 64'(exp_q.size()), 64'd1);
          else begin
            e = exp_q.pop_front();
            check("res_data", 64'(res_data), 64'(e[31:0]));
            check("res_err", 64'(res_err), 64'(e[32]));
          end
        end
        prev_start = eng_start;
        prev_valid = res_valid;
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int rise, s0;
    logic [15:0] ra, rb, rc, rd;
    rst_n = 1'b0; job_valid = 1'b0;
    job_a = 16'd0; job_b = 16'd0; job_c = 16'd0; job_d = 16'd0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_reset_state("reset");

    // Single job, engine done 10 cycles after start
    rr_level = 1'b1; eng_delay = 10; s0 = start_count;
    push_job(16'd6, 16'd8, 16'd2, 16'd3, 1'b0);
    wait_res(200, rise);
    check("single_res", 64'({res_err, res_data}), 64'({1'b0, 32'h0000_0008}));
    check("single_push_to_start", 64'(start_cyc - push_cyc), 64'd2);
    check("single_done_latency", 64'(rise - start_cyc), 64'd11);
    wait_drain(200);
    check("single_start_count", 64'(start_count - s0), 64'd1);

    // Zero divisor: no launch, error result one cycle after pop
    s0 = start_count;
    push_job(16'd5, 16'd7, 16'd0, 16'd9, 1'b0);
    wait_res(50, rise);
    check("zdiv_res", 64'({res_err, res_data}), 64'({1'b1, 32'hFFFF_FFFF}));
    check("zdiv_latency", 64'(rise - push_cyc), 64'd2);
    wait_drain(50);
    check("zdiv_no_start", 64'(start_count - s0), 64'd0);

    // Silent engine: timeout
    eng_mode = 1;
    push_job(16'd3, 16'd4, 16'd5, 16'd6, 1'b1);
    wait_res(300, rise);
    check("timeout_res", 64'({res_err, res_data}), 64'({1'b1, 32'h0}));
    check("timeout_latency", 64'(rise - start_cyc), 64'(TIMEOUT + 1));
    wait_drain(50);
    eng_mode = 0;

    // Done edge in the timeout cycle wins; one cycle later it loses
    eng_delay = TIMEOUT;
    push_job(16'd100, 16'd200, 16'd3, 16'd7, 1'b0);
    wait_res(300, rise);
    check("edge_at_timeout_res", 64'({res_err, res_data}), 64'({1'b0, 32'd952}));
    check("edge_at_timeout_latency", 64'(rise - start_cyc), 64'(TIMEOUT + 1));
    wait_drain(50);
    eng_delay = TIMEOUT + 1;
    push_job(16'd100, 16'd200, 16'd3, 16'd7, 1'b1);
    wait_res(300, rise);
    check("edge_after_timeout_res", 64'({res_err, res_data}), 64'({1'b1, 32'h0}));
    wait_drain(50);

    // FIFO full with the first result held
    eng_delay = 1; rr_level = 1'b0;
    for (int i = 1; i <= 5; i++) push_job(16'(i * 3), 16'(i + 10), 16'(i), 16'd2, 1'b0);
    @(negedge clk);
    check("full_job_ready", 64'(job_ready), 64'd0);
    check("full_pending", 64'(jobs_pending), 64'd4);
    check("full_res_held", 64'(res_valid), 64'd1);
    rr_level = 1'b1;
    wait_drain(500);
    check("full_pending_zero", 64'(jobs_pending), 64'd0);

    // Done stuck high: no completion, then a drop and re-rise completes
    eng_delay = 0; eng_mode = 2;
    repeat (2) @(negedge clk);
    push_job(16'd9, 16'd9, 16'd3, 16'd3, 1'b1);
    wait_res(300, rise);
    check("stuck_timeout_latency", 64'(rise - start_cyc), 64'(TIMEOUT + 1));
    wait_drain(50);
    eng_mode = 3;
    push_job(16'd9, 16'd9, 16'd3, 16'd3, 1'b0);
    wait_res(300, rise);
    check("rerise_res", 64'({res_err, res_data}), 64'({1'b0, 32'd9}));
    check("rerise_latency", 64'(rise - start_cyc), 64'd6);
    wait_drain(50);
    eng_mode = 0;
    repeat (2) @(negedge clk);

    // Reset in the middle of WAIT with a second job queued
    eng_mode = 1;
    push_job(16'd1, 16'd2, 16'd3, 16'd4, 1'b1);
    push_job(16'd5, 16'd6, 16'd7, 16'd8, 1'b0);
    repeat (5) @(negedge clk);
    check("pre_reset_busy", 64'({busy, jobs_pending}), 64'({1'b1, 3'd1}));
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check_reset_state("midwait_reset");
    eng_mode = 0;
    push_job(16'd40, 16'd50, 16'd4, 16'd5, 1'b0);
    wait_res(200, rise);
    check("post_reset_res", 64'({res_err, res_data}), 64'({1'b0, 32'd100}));
    wait_drain(100);

    // Random jobs with random backpressure and engine delays
    rr_random = 1'b1;
    for (int i = 0; i < 40; i++) begin
      ra = 16'($urandom); rb = 16'($urandom);
      rc = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom_range(1, 300));
      rd = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom_range(1, 300));
      push_job(ra, rb, rc, rd, 1'b0);
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end
    rr_random = 1'b0; rr_level = 1'b1;
    wait_drain(8000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
